// File: rtl/state_dump_pkg.sv
// state_dump shared types: FSM encoding and index-width helper.
// Optional parity storage/output is enabled with STATE_DUMP_PARITY_EN.
package state_dump_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        STREAM  = 2'd2,
        DONE    = 2'd3
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/state_dump_if.sv
// Beat stream from state_dump to its consumer (valid/ready + markers).
// out_parity exists only when STATE_DUMP_PARITY_EN is defined.
interface state_dump_if #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 3
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
`ifdef STATE_DUMP_PARITY_EN
    logic             out_parity;
`endif

    modport master (
`ifdef STATE_DUMP_PARITY_EN
        output out_parity,
`endif
        output out_valid,
        output out_data,
        output out_idx,
        output out_last,
        input  out_ready
    );

    modport slave (
`ifdef STATE_DUMP_PARITY_EN
        input  out_parity,
`endif
        input  out_valid,
        input  out_data,
        input  out_idx,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/state_dump_buf.sv
// Snapshot storage: parallel load of all registers, one indexed read.
// Stores a per-entry parity bit when STATE_DUMP_PARITY_EN is defined.
module state_dump_buf #(
    parameter int NUM_REGS = 8,
    parameter int WIDTH    = 32,
    parameter int IDX_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst_aH,
    input  logic                      load,
    input  logic [NUM_REGS*WIDTH-1:0] snap_in,
    input  logic [IDX_W-1:0]          rd_idx,
`ifdef STATE_DUMP_PARITY_EN
    output logic                      rd_par,
`endif
    output logic [WIDTH-1:0]          rd_data
);

    logic [WIDTH-1:0] mem [NUM_REGS];

    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            for (int k = 0; k < NUM_REGS; k++)
                mem[k] <= '0;
        end else if (load) begin
            for (int k = 0; k < NUM_REGS; k++)
                mem[k] <= snap_in[k*WIDTH +: WIDTH];
        end
    end

    assign rd_data = mem[rd_idx];

`ifdef STATE_DUMP_PARITY_EN
    // Parity is taken at capture time so the read path stays a plain mux.
    logic par [NUM_REGS];

    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            for (int k = 0; k < NUM_REGS; k++)
                par[k] <= 1'b0;
        end else if (load) begin
            for (int k = 0; k < NUM_REGS; k++)
                par[k] <= ^snap_in[k*WIDTH +: WIDTH];
        end
    end

    assign rd_par = par[rd_idx];
`endif

endmodule

// File: rtl/state_dump.sv
// Debug readout engine: snapshots NUM_REGS registers, streams them out.
// Define STATE_DUMP_PARITY_EN to add the out_parity output.
module state_dump
    import state_dump_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      rst_aH,
    input  logic                      start,
    input  logic [NUM_REGS*WIDTH-1:0] snap_in,
    output logic                      busy,
    output logic                      done,
    state_dump_if.master              dump
);

    localparam int IDX_W = idx_w(NUM_REGS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    state_t           state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic             load;
    logic             xfer;
    logic             at_last;
    logic [WIDTH-1:0] rd_data;
`ifdef STATE_DUMP_PARITY_EN
    logic             rd_par;
`endif

    state_dump_buf #(
        .NUM_REGS (NUM_REGS),
        .WIDTH    (WIDTH),
        .IDX_W    (IDX_W)
    ) u_buf (
        .clk     (clk),
        .rst_aH  (rst_aH),
        .load    (load),
        .snap_in (snap_in),
        .rd_idx  (idx),
`ifdef STATE_DUMP_PARITY_EN
        .rd_par  (rd_par),
`endif
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    assign at_last = (idx == LAST_IDX);
    assign xfer    = dump.out_valid & dump.out_ready;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    idx_n   = '0;
                    state_n = CAPTURE;
                end
            end
            CAPTURE: state_n = STREAM;
            STREAM: begin
                if (xfer) begin
                    if (at_last) begin
                        idx_n   = '0;
                        state_n = DONE;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            DONE: state_n = IDLE;
        endcase
    end

    assign dump.out_valid = (state == STREAM);
    assign dump.out_data  = rd_data;
    assign dump.out_idx   = idx;
    assign dump.out_last  = dump.out_valid & at_last;
`ifdef STATE_DUMP_PARITY_EN
    assign dump.out_parity = dump.out_valid & rd_par;
`endif

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_state_dump.sv
// Directed bench for state_dump (NUM_REGS=4, WIDTH=8).
// Parity checks are compiled in with STATE_DUMP_PARITY_EN.
module tb_state_dump;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic         clk = 1'b0;
    logic         rst_aH = 1'b1;
    logic         start = 1'b0;
    logic [N*W-1:0] snap_in;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    logic [7:0] exp_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    state_dump_if #(.WIDTH(W), .IDX_W(IW)) dif ();

    state_dump #(
        .NUM_REGS (N),
        .WIDTH    (W)
    ) dut (
        .clk     (clk),
        .rst_aH  (rst_aH),
        .start   (start),
        .snap_in (snap_in),
        .busy    (busy),
        .done    (done),
        .dump    (dif.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (done) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input int i,
                        input logic [7:0] d);
        chk({tag, "_valid"}, 32'(dif.out_valid), 32'd1);
        chk({tag, "_idx"}, 32'(dif.out_idx), 32'(i));
        chk({tag, "_data"}, 32'(dif.out_data), 32'(d));
        chk({tag, "_last"}, 32'(dif.out_last), 32'(i == 3));
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_valid"}, 32'(dif.out_valid), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        dif.out_ready = 1'b1;
        snap_in = {8'h44, 8'h33, 8'h22, 8'h11};
        #1;
        idle_chk("rst");
        chk("rst_idx", 32'(dif.out_idx), 32'd0);
        chk("rst_data", 32'(dif.out_data), 32'd0);
        chk("rst_last", 32'(dif.out_last), 32'd0);
        step();
        rst_aH = 1'b0;
        step();
        idle_chk("idle0");

        // basic dump, ready held high
        done_cnt = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("b_cap_busy", 32'(busy), 32'd1);
        chk("b_cap_valid", 32'(dif.out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            beat("b", i, exp_b[i]);
        end
        step();
        chk("b_done", 32'(done), 32'd1);
        chk("b_done_busy", 32'(busy), 32'd1);
        chk("b_done_valid", 32'(dif.out_valid), 32'd0);
        step();
        idle_chk("b_end");
        chk("b_done_cnt", 32'(done_cnt), 32'd1);

        // backpressure, frozen snapshot, start while busy
        done_cnt = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        snap_in = {N*W{1'b1}};
        step();
        beat("s0", 0, 8'h11);
        step();
        beat("s1", 1, 8'h22);
        dif.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            beat("hold", 1, 8'h22);
        end
        dif.out_ready = 1'b1;
        step();
        beat("s2", 2, 8'h33);
        start = 1'b1;
        step();
        beat("s3", 3, 8'h44);
        start = 1'b0;
        step();
        chk("s_done", 32'(done), 32'd1);
        step();
        idle_chk("s_end");
        chk("s_done_cnt", 32'(done_cnt), 32'd1);

        // start held high: back-to-back dumps with one IDLE gap
        snap_in = {8'h44, 8'h33, 8'h22, 8'h11};
        done_cnt = 0;
        start = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            beat("h", i, exp_b[i]);
        end
        step();
        chk("h_done", 32'(done), 32'd1);
        step();
        idle_chk("h_gap");
        step();
        chk("h2_cap_busy", 32'(busy), 32'd1);
        chk("h2_cap_valid", 32'(dif.out_valid), 32'd0);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            beat("h2", i, exp_b[i]);
        end
        step();
        step();
        idle_chk("h2_end");
        chk("h_done_cnt", 32'(done_cnt), 32'd2);

        // asynchronous reset in the middle of a dump
        done_cnt = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            beat("r", i, exp_b[i]);
        end
        #2;
        rst_aH = 1'b1;
        #1;
        idle_chk("r_async");
        chk("r_idx", 32'(dif.out_idx), 32'd0);
        chk("r_data", 32'(dif.out_data), 32'd0);
        step();
        step();
        rst_aH = 1'b0;
        step();
        idle_chk("r_after");
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            beat("r2", i, exp_b[i]);
        end
        step();
        chk("r2_done", 32'(done), 32'd1);
        step();
        chk("r_done_cnt", 32'(done_cnt), 32'd1);

`ifdef STATE_DUMP_PARITY_EN
        chk("p_idle", 32'(dif.out_parity), 32'd0);
        snap_in = {8'h80, 8'hFF, 8'h03, 8'h07};
        start = 1'b1;
        step();
        start = 1'b0;
        chk("p_cap", 32'(dif.out_parity), 32'd0);
        step();
        beat("p0", 0, 8'h07);
        chk("p_07", 32'(dif.out_parity), 32'd1);
        step();
        beat("p1", 1, 8'h03);
        chk("p_03", 32'(dif.out_parity), 32'd0);
        step();
        chk("p_ff", 32'(dif.out_parity), 32'd0);
        step();
        chk("p_80", 32'(dif.out_parity), 32'd1);
        step();
        chk("p_done", 32'(dif.out_parity), 32'd0);
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/state_dump.md
Name: state_dump

Overview:
- Test/debug readout engine: the read-side counterpart to the force-init path on the team's registers.
- On a start pulse it captures a parallel snapshot of NUM_REGS registers, each WIDTH bits wide.
- It then streams the snapshot out one register per beat over a valid/ready interface, with index and last markers.
- Sits beside the architectural state (RAT, ARF, ROB pointers) so benches and debug logic can read state without perturbing it.

Parameters:
- NUM_REGS, 8, number of registers captured per dump (>=1).
- WIDTH, 32, bits per register/beat.
- IDX_W, max(1,$clog2(NUM_REGS)), width of out_idx; derived, not overridden.

Ports:
- clk  in  1  clock.
- rst_aH  in  1  reset, asynchronous, active-high.
- start  in  1  begin dump; sampled only in IDLE.
- snap_in  in  NUM_REGS*WIDTH  flattened live register contents; reg k = snap_in[k*WIDTH +: WIDTH].
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts beat.
- out_data  out  WIDTH  snapshot of reg out_idx.
- out_idx  out  IDX_W  index of current beat.
- out_last  out  1  high when out_idx == NUM_REGS-1 and out_valid.
- busy  out  1  high in CAPTURE/STREAM/DONE.
- done  out  1  single-cycle pulse after last beat accepted.
- out_parity  out  1  only with STATE_DUMP_PARITY_EN.

Behaviour:
- One clock; reset asynchronous, active-high (rst_aH). All state and outputs clear immediately on assertion, regardless of clk.
- Reset values: state=IDLE; out_valid=0; out_data=0; out_idx=0; out_last=0; busy=0; done=0; snapshot buffer=0; out_parity=0 when present.
- FSM states: IDLE, CAPTURE, STREAM, DONE.
- IDLE:
  - start=1 at a rising edge -> snapshot buffer <= snap_in (whole vector, same edge), idx <= 0, next=CAPTURE.
  - start=0 -> stay.
- CAPTURE: one cycle, busy=1, out_valid=0; next=STREAM. Fixed latency: first out_valid is 2 cycles after the start edge.
- STREAM:
  - out_valid=1; out_data = buffer[idx]; out_idx = idx.
  - Transfer = out_valid & out_ready at a rising edge.
  - On transfer with idx<NUM_REGS-1: idx <= idx+1, stay in STREAM.
  - On transfer with idx==NUM_REGS-1: next=DONE, idx <= 0.
  - With out_ready=0: out_data/out_idx/out_last hold stable and out_valid stays 1; valid is never withdrawn.
  - Back-to-back transfers sustain one beat per cycle.
- DONE: done=1 for exactly one cycle, busy=1, out_valid=0; next=IDLE.
- Boundary cases:
  - start while busy: ignored, no re-capture, no queuing.
  - start held high continuously: a new dump begins in the first IDLE cycle after DONE, so dumps are separated by at least one IDLE cycle.
  - snap_in changes after capture: no effect on beats; the snapshot is frozen.
  - NUM_REGS=1: single beat with out_last=1; idx stays 0.
  - idx never wraps past NUM_REGS-1.
  - Reset mid-STREAM: the dump aborts, no done pulse; the next start after deassertion begins a fresh dump from idx 0.

Optional Feature:
- Macro: STATE_DUMP_PARITY_EN.
- Defined:
  - Adds output out_parity = ^out_data (even parity), valid whenever out_valid=1; 0 otherwise and at reset.
  - Parity is computed from the buffer at capture and stored alongside each entry; it is not computed combinationally from out_data.
- Undefined: port and storage are absent; behaviour otherwise identical.

Decomposition:
- Package state_dump_pkg holds:
  - typedef enum of the four FSM states (2-bit encoding: IDLE=0, CAPTURE=1, STREAM=2, DONE=3);
  - function idx_w(n) returning max(1,$clog2(n)).
- One sub-module, state_dump_buf:
  - NUM_REGS x WIDTH (plus parity bit when enabled) storage;
  - parallel load enable plus one combinational read port indexed by idx;
  - same async active-high reset.
- FSM, index counter and handshake stay in state_dump.

Test Plan:
- Basic dump: NUM_REGS=4, WIDTH=8, snap_in={8'h44,8'h33,8'h22,8'h11}, start pulse, out_ready=1 -> beats 11,22,33,44 on idx 0..3 on consecutive cycles, first valid 2 cycles after start; out_last only on idx 3; done pulses one cycle later; busy falls with the return to IDLE.
- Backpressure: out_ready=0 for 3 cycles at idx 1 -> out_data=22, idx=1, valid=1 held unchanged; the beat completes when ready=1, with no skipped or duplicated beats.
- Snapshot isolation: change snap_in to all 8'hFF during STREAM -> beats still 11,22,33,44.
- Start while busy: pulse start at idx 2 -> ignored; exactly 4 beats, one done pulse; start held continuously -> second dump begins after one IDLE cycle.
- Async reset mid-dump: assert rst_aH between edges at idx 2 -> out_valid/busy drop to 0 immediately, no done pulse; a subsequent start yields a full 4-beat dump from idx 0.
- Parity (STATE_DUMP_PARITY_EN defined): beat 8'h07 -> out_parity=1; 8'h03 -> out_parity=0; build without the macro compiles with no out_parity port.
